// File: rtl/psram_fml_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// psram_arb_pkg
// Shared constants for the PSRAM FML arbiter:
//   - FSM state encodings (IDLE -> BUSY -> GAP -> IDLE)
//   - FML cycle-type identifiers used to detect the last beat of a transaction
//   - watchdog counter width
//   - helper that classifies a cti value as transaction-terminating
// ----------------------------------------------------------------------------
package psram_arb_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam logic [2:0] CTI_CLASSIC = 3'd0;
    localparam logic [2:0] CTI_INCR    = 3'd2;
    localparam logic [2:0] CTI_END     = 3'd7;

    localparam int WD_W = 12;

    // Request fields that follow the owner through the output mux.
    typedef struct packed {
        logic [2:0] cti;
        logic [3:0] sel;
        logic       we;
    } fml_ctl_t;

    // A beat acknowledged with cti CLASSIC or END closes the transaction;
    // every other value (INCR in particular) keeps the grant.
    function automatic logic cti_is_last(input logic [2:0] cti);
        return (cti == CTI_CLASSIC) || (cti == CTI_END);
    endfunction

endpackage

// File: rtl/psram_fml_arbiter_if.sv
// ----------------------------------------------------------------------------
// psram_fml_arbiter_if
// Bundles both sides of the arbiter.
//   Master side (NM requesters): m_adr, m_stb, m_we, m_cti, m_sel, m_di in;
//                                m_eack (per master), m_do (broadcast) out.
//   Controller side:             s_adr, s_stb, s_we, s_cti, s_sel, s_di out;
//                                s_eack, s_do, s_ready in.
// Modports are written from the arbiter's point of view:
//   slave  - the arbiter acting as the slave of the NM masters
//   master - the arbiter acting as the single master of the controller
// ----------------------------------------------------------------------------
interface psram_fml_arbiter_if #(
    parameter int NM    = 3,
    parameter int ADR_W = 23
);
    logic [NM*ADR_W-1:0] m_adr;
    logic [NM-1:0]       m_stb;
    logic [NM-1:0]       m_we;
    logic [NM*3-1:0]     m_cti;
    logic [NM*4-1:0]     m_sel;
    logic [NM*32-1:0]    m_di;
    logic [NM-1:0]       m_eack;
    logic [31:0]         m_do;

    logic [ADR_W-1:0]    s_adr;
    logic                s_stb;
    logic                s_we;
    logic [2:0]          s_cti;
    logic [3:0]          s_sel;
    logic [31:0]         s_di;
    logic                s_eack;
    logic [31:0]         s_do;
    logic                s_ready;

    modport slave (
        input  m_adr, m_stb, m_we, m_cti, m_sel, m_di,
        output m_eack, m_do
    );

    modport master (
        output s_adr, s_stb, s_we, s_cti, s_sel, s_di,
        input  s_eack, s_do, s_ready
    );

endinterface

// File: rtl/psram_fml_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// arb_rr_pick
// Combinational rotating priority encoder.
//   req   in  NM     request vector
//   ptr   in  PTR_W  index that has highest priority in round-robin mode
//   fixed in  1      1 = ignore ptr, index 0 has highest priority
//   win   out NM     one-hot winner (all zero when nothing requests)
//   valid out 1      at least one request present
// ----------------------------------------------------------------------------
module arb_rr_pick #(
    parameter int NM    = 3,
    parameter int PTR_W = 2
) (
    input  logic [NM-1:0]    req,
    input  logic [PTR_W-1:0] ptr,
    input  logic             fixed,
    output logic [NM-1:0]    win,
    output logic             valid
);

    logic [PTR_W-1:0] start_s;
    logic [PTR_W:0]   sum_s;
    logic             found_s;

    // Scan NM positions starting at start_s, wrapping, first requester wins.
    always_comb begin
        win     = '0;
        found_s = 1'b0;
        sum_s   = '0;
        start_s = fixed ? '0 : ptr;
        for (int k = 0; k < NM; k++) begin
            // start + k < 2*NM, so a single conditional subtract wraps it
            sum_s = {1'b0, start_s} + (PTR_W+1)'(k);
            if (sum_s >= (PTR_W+1)'(NM)) begin
                sum_s = sum_s - (PTR_W+1)'(NM);
            end else begin
                sum_s = sum_s;
            end
            if (!found_s && req[sum_s[PTR_W-1:0]]) begin
                win[sum_s[PTR_W-1:0]] = 1'b1;
                found_s               = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
        valid = found_s;
    end

endmodule

// File: rtl/psram_fml_arbiter.sv
// ----------------------------------------------------------------------------
// psram_fml_arbiter
// Shares one FML slave port of the PSRAM controller between NM masters.
// A grant covers a whole transaction (single beat or incrementing burst
// ending on cti=7), and one GAP cycle with s_stb low separates transactions
// so the controller returns to idle. A watchdog aborts a transaction that
// goes TIMEOUT cycles without an acknowledge.
//   clk, rst     clock, synchronous active-high reset
//   mbus         master side (slave modport): requests in, eack / read data out
//   sbus         controller side (master modport): muxed request out, eack in
//   grant        one-hot current owner (registered)
//   timeout_err  one-cycle pulse in the BUSY cycle where the watchdog fires
// ----------------------------------------------------------------------------
module psram_fml_arbiter
    import psram_arb_pkg::*;
#(
    parameter int NM         = 3,
    parameter int ADR_W      = 23,
    parameter int FIXED_PRIO = 0,
    parameter int TIMEOUT    = 4095
) (
    input  logic                 clk,
    input  logic                 rst,
    psram_fml_arbiter_if.slave   mbus,
    psram_fml_arbiter_if.master  sbus,
    output logic [NM-1:0]        grant,
    output logic                 timeout_err
);

    localparam int              PTR_W    = (NM > 1) ? $clog2(NM) : 1;
    localparam logic            FIXED_B  = (FIXED_PRIO != 0);
    localparam logic            WD_EN    = (TIMEOUT > 0);
    localparam logic [WD_W-1:0] WD_LIMIT = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;

    logic [1:0]       state_q,    state_d;
    logic [NM-1:0]    grant_q,    grant_d;
    logic [PTR_W-1:0] rr_ptr_q,   rr_ptr_d;
    logic [WD_W-1:0]  wd_cnt_q,   wd_cnt_d;
    logic [ADR_W-1:0] last_adr_q, last_adr_d;
    logic [2:0]       last_cti_q, last_cti_d;
    logic [3:0]       last_sel_q, last_sel_d;
    logic [31:0]      last_di_q,  last_di_d;

    logic [ADR_W-1:0] own_adr_s;
    logic             own_stb_s;
    fml_ctl_t         own_ctl_s;
    logic [31:0]      own_di_s;
    logic [PTR_W-1:0] own_idx_s;
    logic [PTR_W-1:0] next_ptr_s;
    logic [NM-1:0]    pick_win_s;
    logic             pick_valid_s;
    logic             busy_s;
    logic             timeout_s;

    arb_rr_pick #(
        .NM    (NM),
        .PTR_W (PTR_W)
    ) u_pick (
        .req   (mbus.m_stb),
        .ptr   (rr_ptr_q),
        .fixed (FIXED_B),
        .win   (pick_win_s),
        .valid (pick_valid_s)
    );

    assign busy_s = (state_q == ST_BUSY);

    // AND-OR mux of the owner's request fields, plus its binary index.
    always_comb begin
        own_adr_s = '0;
        own_stb_s = 1'b0;
        own_ctl_s = '0;
        own_di_s  = '0;
        own_idx_s = '0;
        for (int i = 0; i < NM; i++) begin
            own_adr_s     = own_adr_s     | (mbus.m_adr[i*ADR_W +: ADR_W] & {ADR_W{grant_q[i]}});
            own_stb_s     = own_stb_s     | (mbus.m_stb[i] & grant_q[i]);
            own_ctl_s.we  = own_ctl_s.we  | (mbus.m_we[i] & grant_q[i]);
            own_ctl_s.cti = own_ctl_s.cti | (mbus.m_cti[i*3 +: 3] & {3{grant_q[i]}});
            own_ctl_s.sel = own_ctl_s.sel | (mbus.m_sel[i*4 +: 4] & {4{grant_q[i]}});
            own_di_s      = own_di_s      | (mbus.m_di[i*32 +: 32] & {32{grant_q[i]}});
            own_idx_s     = own_idx_s     | (PTR_W'(i) & {PTR_W{grant_q[i]}});
        end
    end

    // Pointer moves just past the owner so the next scan starts there.
    always_comb begin
        if (own_idx_s == PTR_W'(NM - 1)) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = own_idx_s + PTR_W'(1);
        end
    end

    // Controller-side outputs: live from the owner in BUSY, held otherwise.
    // rst gates s_stb combinationally so a reset cuts a transaction at once.
    always_comb begin
        sbus.s_stb = busy_s & own_stb_s & ~rst;
        sbus.s_we  = busy_s & own_ctl_s.we;
        if (busy_s) begin
            sbus.s_adr = own_adr_s;
            sbus.s_cti = own_ctl_s.cti;
            sbus.s_sel = own_ctl_s.sel;
            sbus.s_di  = own_di_s;
        end else begin
            sbus.s_adr = last_adr_q;
            sbus.s_cti = last_cti_q;
            sbus.s_sel = last_sel_q;
            sbus.s_di  = last_di_q;
        end
    end

    // Acknowledge only the owner, and only while it is still strobing, so a
    // master that has given up never sees a stale eack.
    always_comb begin
        mbus.m_eack = grant_q & {NM{busy_s & own_stb_s & sbus.s_eack}};
        mbus.m_do   = sbus.s_do;
    end

    // Next-state logic: FSM, grant, round-robin pointer, watchdog, hold regs.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        wd_cnt_d   = wd_cnt_q;
        last_adr_d = last_adr_q;
        last_cti_d = last_cti_q;
        last_sel_d = last_sel_q;
        last_di_d  = last_di_q;
        timeout_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sbus.s_ready && pick_valid_s) begin
                    state_d  = ST_BUSY;
                    grant_d  = pick_win_s;
                    wd_cnt_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                last_adr_d = own_adr_s;
                last_cti_d = own_ctl_s.cti;
                last_sel_d = own_ctl_s.sel;
                last_di_d  = own_di_s;
                if (sbus.s_eack) begin
                    wd_cnt_d = '0;
                end else if (wd_cnt_q != {WD_W{1'b1}}) begin
                    wd_cnt_d = wd_cnt_q + WD_W'(1);
                end else begin
                    wd_cnt_d = wd_cnt_q;
                end
                if (!own_stb_s) begin
                    state_d  = ST_GAP;
                    rr_ptr_d = next_ptr_s;
                end else if (sbus.s_eack) begin
                    if (cti_is_last(own_ctl_s.cti)) begin
                        state_d  = ST_GAP;
                        rr_ptr_d = next_ptr_s;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end else if (WD_EN && (wd_cnt_q == WD_LIMIT)) begin
                    // this is the TIMEOUT-th cycle without an acknowledge
                    state_d   = ST_GAP;
                    rr_ptr_d  = next_ptr_s;
                    timeout_s = 1'b1;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            wd_cnt_q   <= '0;
            last_adr_q <= '0;
            last_cti_q <= '0;
            last_sel_q <= '0;
            last_di_q  <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            wd_cnt_q   <= wd_cnt_d;
            last_adr_q <= last_adr_d;
            last_cti_q <= last_cti_d;
            last_sel_q <= last_sel_d;
            last_di_q  <= last_di_d;
        end
    end

    assign grant       = grant_q;
    assign timeout_err = timeout_s;

endmodule

// File: tb/tb_psram_fml_arbiter.sv
// ----------------------------------------------------------------------------
// tb_psram_fml_arbiter
// Directed bench for psram_fml_arbiter. Two instances share one stimulus set:
// dut_a is round-robin, dut_b fixed priority; both use a 16-cycle watchdog.
// sel_b chooses whose outputs are compared.
// ----------------------------------------------------------------------------
module tb_psram_fml_arbiter;

    localparam int NM    = 3;
    localparam int ADR_W = 23;

    logic clk = 1'b0;
    logic rst;

    logic [NM*ADR_W-1:0] m_adr_v;
    logic [NM-1:0]       m_stb_v;
    logic [NM-1:0]       m_we_v;
    logic [NM*3-1:0]     m_cti_v;
    logic [NM*4-1:0]     m_sel_v;
    logic [NM*32-1:0]    m_di_v;
    logic                s_eack_v;
    logic [31:0]         s_do_v;
    logic                s_ready_v;

    logic [NM-1:0] grant_a, grant_b;
    logic          to_a, to_b;
    bit            sel_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    psram_fml_arbiter_if #(.NM(NM), .ADR_W(ADR_W)) bus_a ();
    psram_fml_arbiter_if #(.NM(NM), .ADR_W(ADR_W)) bus_b ();

    assign bus_a.m_adr   = m_adr_v;
    assign bus_a.m_stb   = m_stb_v;
    assign bus_a.m_we    = m_we_v;
    assign bus_a.m_cti   = m_cti_v;
    assign bus_a.m_sel   = m_sel_v;
    assign bus_a.m_di    = m_di_v;
    assign bus_a.s_eack  = s_eack_v;
    assign bus_a.s_do    = s_do_v;
    assign bus_a.s_ready = s_ready_v;
    assign bus_b.m_adr   = m_adr_v;
    assign bus_b.m_stb   = m_stb_v;
    assign bus_b.m_we    = m_we_v;
    assign bus_b.m_cti   = m_cti_v;
    assign bus_b.m_sel   = m_sel_v;
    assign bus_b.m_di    = m_di_v;
    assign bus_b.s_eack  = s_eack_v;
    assign bus_b.s_do    = s_do_v;
    assign bus_b.s_ready = s_ready_v;

    psram_fml_arbiter #(.NM(NM), .ADR_W(ADR_W), .FIXED_PRIO(0), .TIMEOUT(16)) dut_a (
        .clk         (clk),
        .rst         (rst),
        .mbus        (bus_a),
        .sbus        (bus_a),
        .grant       (grant_a),
        .timeout_err (to_a)
    );

    psram_fml_arbiter #(.NM(NM), .ADR_W(ADR_W), .FIXED_PRIO(1), .TIMEOUT(16)) dut_b (
        .clk         (clk),
        .rst         (rst),
        .mbus        (bus_b),
        .sbus        (bus_b),
        .grant       (grant_b),
        .timeout_err (to_b)
    );

    // Observed outputs of the instance under check.
    logic [NM-1:0]    grant_s, eack_s;
    logic             stb_s, we_s, to_s;
    logic [ADR_W-1:0] adr_s;
    logic [2:0]       cti_s;
    logic [31:0]      di_s, do_s;
    assign grant_s = sel_b ? grant_b       : grant_a;
    assign eack_s  = sel_b ? bus_b.m_eack  : bus_a.m_eack;
    assign stb_s   = sel_b ? bus_b.s_stb   : bus_a.s_stb;
    assign we_s    = sel_b ? bus_b.s_we    : bus_a.s_we;
    assign to_s    = sel_b ? to_b          : to_a;
    assign adr_s   = sel_b ? bus_b.s_adr   : bus_a.s_adr;
    assign cti_s   = sel_b ? bus_b.s_cti   : bus_a.s_cti;
    assign di_s    = sel_b ? bus_b.s_di    : bus_a.s_di;
    assign do_s    = sel_b ? bus_b.m_do    : bus_a.m_do;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_master(input int i, input logic [ADR_W-1:0] adr, input logic [2:0] cti);
        m_adr_v[i*ADR_W +: ADR_W] = adr;
        m_cti_v[i*3 +: 3]         = cti;
    endtask

    // Called in an IDLE cycle with requests driven; runs one single-beat
    // transaction for master idx and returns in the following IDLE cycle.
    // Masters in drop_mask lower their strobe during the GAP cycle.
    task automatic serve(input int idx, input logic [NM-1:0] drop_mask, input string tag);
        logic [NM-1:0]    oh;
        logic [ADR_W-1:0] exp_adr;
        logic [31:0]      exp_di;
        oh      = '0;
        oh[idx] = 1'b1;
        exp_adr = m_adr_v[idx*ADR_W +: ADR_W];
        exp_di  = m_di_v[idx*32 +: 32];
        tick();
        check_val({tag, "_grant"}, 32'(grant_s), 32'(oh));
        check_val({tag, "_stb"},   32'(stb_s),   32'd1);
        check_val({tag, "_adr"},   32'(adr_s),   32'(exp_adr));
        check_val({tag, "_we"},    32'(we_s),    32'(m_we_v[idx]));
        check_val({tag, "_di"},    32'(di_s),    exp_di);
        s_eack_v = 1'b1;
        s_do_v   = 32'hD00D_0000 + 32'(idx);
        #1;
        check_val({tag, "_eack"},  32'(eack_s),  32'(oh));
        check_val({tag, "_do"},    32'(do_s),    32'hD00D_0000 + 32'(idx));
        tick();
        s_eack_v = 1'b0;
        m_stb_v  = m_stb_v & ~drop_mask;
        #1;
        check_val({tag, "_gap_stb"},   32'(stb_s),   32'd0);
        check_val({tag, "_gap_grant"}, 32'(grant_s), 32'(oh));
        check_val({tag, "_gap_adr"},   32'(adr_s),   32'(exp_adr));
        check_val({tag, "_gap_we"},    32'(we_s),    32'd0);
        check_val({tag, "_gap_eack"},  32'(eack_s),  32'd0);
        tick();
        check_val({tag, "_idle_grant"}, 32'(grant_s), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        sel_b     = 1'b0;
        m_stb_v   = '0;
        m_we_v    = 3'b010;
        m_sel_v   = {4'h4, 4'h2, 4'h1};
        m_di_v    = {32'hA5A5_0002, 32'hA5A5_0001, 32'hA5A5_0000};
        m_adr_v   = '0;
        m_cti_v   = '0;
        s_eack_v  = 1'b0;
        s_do_v    = '0;
        s_ready_v = 1'b0;
        for (int i = 0; i < NM; i++) begin
            set_master(i, ADR_W'(32'h1000 * (i + 1)), 3'd0);
        end
        tick();
        tick();

        // Reset state
        check_val("rst_grant", 32'(grant_s), 32'd0);
        check_val("rst_stb",   32'(stb_s),   32'd0);
        check_val("rst_to",    32'(to_s),    32'd0);
        check_val("rst_eack",  32'(eack_s),  32'd0);

        // s_ready low blocks grants; first grant after it rises (leaves rr_ptr=0)
        rst        = 1'b0;
        m_stb_v[2] = 1'b1;
        tick();
        tick();
        tick();
        check_val("noready_grant", 32'(grant_s), 32'd0);
        check_val("noready_stb",   32'(stb_s),   32'd0);
        s_ready_v = 1'b1;
        serve(2, 3'b100, "ready");

        // Masters 0 and 2 together: 0 first, then 2
        m_stb_v = 3'b101;
        serve(0, 3'b001, "t1_m0");
        serve(2, 3'b100, "t1_m2");

        // Round-robin with all three requesting continuously
        m_stb_v = 3'b111;
        serve(0, 3'b000, "rr0");
        serve(1, 3'b000, "rr1");
        serve(2, 3'b000, "rr2");
        serve(0, 3'b000, "rr3");
        serve(1, 3'b000, "rr4");
        serve(2, 3'b111, "rr5");

        // Burst from master 1, master 0 joins mid-burst
        set_master(1, 23'h000100, 3'd2);
        m_stb_v[1] = 1'b1;
        tick();
        check_val("bu_grant", 32'(grant_s), 32'b010);
        check_val("bu_cti",   32'(cti_s),   32'd2);
        for (int b = 0; b < 4; b++) begin
            set_master(1, ADR_W'(32'h100 + 32'(4 * b)), (b == 3) ? 3'd7 : 3'd2);
            s_eack_v = 1'b1;
            if (b == 1) begin
                m_stb_v[0] = 1'b1;
            end
            #1;
            check_val($sformatf("bu_eack%0d", b), 32'(eack_s), 32'b010);
            check_val($sformatf("bu_adr%0d", b),  32'(adr_s),  32'h100 + 32'(4 * b));
            tick();
            if (b < 3) begin
                check_val($sformatf("bu_hold%0d", b), 32'(grant_s), 32'b010);
                check_val($sformatf("bu_stb%0d", b),  32'(stb_s),   32'd1);
            end
        end
        s_eack_v   = 1'b0;
        m_stb_v[1] = 1'b0;
        #1;
        check_val("bu_gap_stb",   32'(stb_s),   32'd0);
        check_val("bu_gap_grant", 32'(grant_s), 32'b010);
        check_val("bu_gap_cti",   32'(cti_s),   32'd7);
        check_val("bu_gap_adr",   32'(adr_s),   32'h10C);
        tick();
        check_val("bu_idle_grant", 32'(grant_s), 32'd0);
        set_master(1, 23'h002000, 3'd0);
        serve(0, 3'b001, "bu_m0");

        // Watchdog: no eack, abort on the 16th BUSY cycle, then master 2
        m_stb_v = 3'b110;
        tick();
        for (int k = 1; k <= 16; k++) begin
            check_val($sformatf("wd_to%0d", k), 32'(to_s), (k == 16) ? 32'd1 : 32'd0);
            if (k == 1 || k == 16) begin
                check_val($sformatf("wd_grant%0d", k), 32'(grant_s), 32'b010);
            end
            if (k < 16) begin
                tick();
            end
        end
        tick();
        check_val("wd_gap_to",    32'(to_s),    32'd0);
        check_val("wd_gap_stb",   32'(stb_s),   32'd0);
        check_val("wd_gap_grant", 32'(grant_s), 32'b010);
        tick();
        check_val("wd_idle_grant", 32'(grant_s), 32'd0);
        serve(2, 3'b110, "wd_next");

        // Reset in the middle of a burst
        set_master(0, 23'h001000, 3'd2);
        m_stb_v[0] = 1'b1;
        tick();
        check_val("rb_grant", 32'(grant_s), 32'b001);
        s_eack_v = 1'b1;
        tick();
        s_eack_v = 1'b0;
        check_val("rb_busy_stb", 32'(stb_s), 32'd1);
        rst = 1'b1;
        #1;
        check_val("rb_rst_stb", 32'(stb_s), 32'd0);
        tick();
        check_val("rb_after_grant", 32'(grant_s), 32'd0);
        check_val("rb_after_stb",   32'(stb_s),   32'd0);
        m_stb_v = '0;
        set_master(0, 23'h001000, 3'd0);
        tick();

        // Fixed priority on dut_b: master 0 wins while it keeps requesting
        sel_b = 1'b1;
        rst   = 1'b0;
        tick();
        m_stb_v = 3'b101;
        serve(0, 3'b000, "fx0");
        serve(0, 3'b000, "fx1");
        serve(0, 3'b001, "fx2");
        serve(2, 3'b100, "fx_m2");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
